full_adder_bist: RTL and testbench

- Self-contained exhaustive tester for the full-adder datapath.
- Drives every operand/carry combination into an external adder instance and samples its sum and carry outputs.
- Compares each response against an internally computed expected value, counts mismatches, and reports pass/fail.
- Sits beside any adder instance as its built-in self test; synthesizable.

---
 rtl/full_adder_bist.sv | 103 ++++++++++
 tb/tb_full_adder_bist.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_bist.sv
// Exhaustive built-in self test for a WIDTH-bit full adder: sweeps {a,b,ci}, checks {co,s}, reports pass/fail.
// Optional macro FA_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module full_adder_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 ci_o,
  input  logic [WIDTH-1:0]     s_i,
  input  logic                 co_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  logic [VW-1:0]    vec;
  logic [3:0]       settle_cnt;
  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;

  assign {a_o, b_o, ci_o} = vec;

  // An X on the response falls into the else branch, so it is flagged as a mismatch.
  always_comb begin
    expected = {1'b0, a_o} + {1'b0, b_o} + (WIDTH + 1)'(ci_o);
    if ({co_i, s_i} == expected) mismatch = 1'b0;
    else                         mismatch = 1'b1;
    err_next = err_cnt;
    if (mismatch && (err_cnt != {ERR_W{1'b1}}))
      err_next = err_cnt + ERR_W'(1);
    last_vec = (vec == {VW{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          err_cnt <= err_next;
          if (mismatch && (err_cnt == '0))
            first_fail <= vec;
`ifdef FA_BIST_STOP_ON_FAIL_EN
          if (last_vec || mismatch) begin
`else
          if (last_vec) begin
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            vec   <= vec + VW'(1);
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// Randomized self-checking bench for full_adder_bist with faulty/healthy adder models and a second
// instance using a 2-bit error counter to exercise saturation.
module tb_full_adder_bist;

  localparam int WIDTH  = 1;
  localparam int SETTLE = 1;
  localparam int ERR_W  = 8;
  localparam int SAT_W  = 2;
  localparam int VW     = 2 * WIDTH + 1;
  localparam int SW     = WIDTH + 1;
  localparam int NVEC   = 1 << VW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [WIDTH-1:0] a_o, b_o, s_i;
  logic             ci_o, co_i, busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
  logic [VW-1:0]    first_fail;

  logic [WIDTH-1:0] a2, b2, s2;
  logic             ci2, co2, busy2, done2, pass2;
  logic [SAT_W-1:0] err2;
  logic [VW-1:0]    ff2;

  logic [WIDTH:0]   sum1, sum2;
  int               faultMode = 0;
  bit               inDone = 1'b0;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  full_adder_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a_o), .b_o(b_o), .ci_o(ci_o), .s_i(s_i), .co_i(co_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail)
  );

  full_adder_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE), .ERR_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a2), .b_o(b2), .ci_o(ci2), .s_i(s2), .co_i(co2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_fail(ff2)
  );

  // Adder under test: mode 0 healthy, 1 carry-out stuck at 0, 2 sum inverted; the second instance always sees an inverted sum.
  always_comb begin
    sum1 = {1'b0, a_o} + {1'b0, b_o} + SW'(ci_o);
    s_i  = sum1[WIDTH-1:0];
    co_i = sum1[WIDTH];
    if (faultMode == 1) co_i = 1'b0;
    if (faultMode == 2) s_i = ~sum1[WIDTH-1:0];
    sum2 = {1'b0, a2} + {1'b0, b2} + SW'(ci2);
    s2   = ~sum2[WIDTH-1:0];
    co2  = sum2[WIDTH];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: walk every vector with integer arithmetic and tally what the tester should report.
  task automatic modelSweep(input int mode, input int errW, output int expErr, output int expFirst, output int lastVec);
    int mask;
    int errMax;
    mask     = (1 << WIDTH) - 1;
    errMax   = (1 << errW) - 1;
    expErr   = 0;
    expFirst = 0;
    lastVec  = NVEC - 1;
    for (int v = 0; v < NVEC; v++) begin
      int a, b, ci, good, obsS, obsC, obs;
      ci   = v & 1;
      b    = (v >> 1) & mask;
      a    = v >> (WIDTH + 1);
      good = a + b + ci;
      obsS = good & mask;
      obsC = good >> WIDTH;
      if (mode == 1) obsC = 0;
      if (mode == 2) obsS = obsS ^ mask;
      obs = (obsC << WIDTH) | obsS;
      if (obs != good) begin
        if (expErr == 0) expFirst = v;
        if (expErr < errMax) expErr++;
`ifdef FA_BIST_STOP_ON_FAIL_EN
        lastVec = v;
        break;
`endif
      end
    end
  endtask

  task automatic applyStimulus(input int mode, input int repulseAt, input int resetAt);
    int expErr, expFirst, lastVec, satErr, satFirst, satLast, expEdge, doneEdge;
    modelSweep(mode, ERR_W, expErr, expFirst, lastVec);
    modelSweep(2, SAT_W, satErr, satFirst, satLast);
    expEdge  = (lastVec + 1) * (SETTLE + 1);
    doneEdge = -1;
    @(negedge clk);
    faultMode = mode;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (inDone) checkOutput("done_drop", done, 0);
    checkOutput("busy_start", busy, 1);
    for (int k = 1; k <= NVEC * (SETTLE + 1) + 10; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (k == resetAt) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_vec", {a_o, b_o, ci_o}, 0);
        checkOutput("rst_flags", {busy, done, pass}, 0);
        checkOutput("rst_err", err_cnt, 0);
        checkOutput("rst_first", first_fail, 0);
        checkOutput("rst_sat", {busy2, done2, err2, ff2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        inDone = 1'b0;
        return;
      end
      if (done) begin
        doneEdge = k;
        break;
      end
      checkOutput("vec", {a_o, b_o, ci_o}, k / (SETTLE + 1));
      if (k == repulseAt && busy) start = 1'b1;
    end
    checkOutput("done_edge", doneEdge, expEdge);
    checkOutput("busy_end", busy, 0);
    checkOutput("err_cnt", err_cnt, expErr);
    checkOutput("first_fail", first_fail, expFirst);
    checkOutput("pass", pass, (expErr == 0) ? 1 : 0);
    checkOutput("last_vec", {a_o, b_o, ci_o}, lastVec);
    checkOutput("sat_done", done2, 1);
    checkOutput("sat_err", err2, satErr);
    checkOutput("sat_first", ff2, satFirst);
    checkOutput("sat_pass", pass2, 0);
    checkOutput("sat_last", {a2, b2, ci2}, satLast);
    inDone = done;
  endtask

  initial begin
    #3;
    checkOutput("reset_vec", {a_o, b_o, ci_o}, 0);
    checkOutput("reset_flags", {busy, done, pass}, 0);
    checkOutput("reset_err", err_cnt, 0);
    checkOutput("reset_first", first_fail, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, -1, -1);
    applyStimulus(1, -1, -1);
    applyStimulus(2, -1, -1);
    applyStimulus(0, 5, -1);
    applyStimulus(0, -1, 11);
    applyStimulus(0, -1, -1);
    for (int i = 0; i < 6; i++) begin
      int mode, rep, rst;
      mode = $urandom_range(0, 2);
      rep  = $urandom_range(1, 14);
      rst  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
      applyStimulus(mode, rep, rst);
    end
    applyStimulus(0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
